// File: rtl/sha256_ctrl_pkg.sv
// Shared definitions for the SHA-256 round sequencing controller.
package sha256_ctrl_pkg;

  localparam int unsigned SHA256_ROUNDS      = 64;
  localparam int unsigned SHA256_SCHED_WORDS = 16;
  localparam int unsigned CTR_W_DEF          = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ROUNDS = 3'd3,
    ST_FINAL  = 3'd4
  } state_t;

endpackage

// File: rtl/sha256_round_ctr.sv
// Round index counter: synchronous clear, count enable, terminal flag at NUM_ROUNDS-1.
module sha256_round_ctr #(
  parameter int unsigned NUM_ROUNDS = 64,
  parameter int unsigned CTR_W      = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CTR_W-1:0] o_cnt,
  output logic             o_tc
);

  logic [CTR_W-1:0] r_cnt;

  // Clear has priority over enable so the caller can restart from any value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CTR_W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == CTR_W'(NUM_ROUNDS - 1));

endmodule

// File: rtl/sha256_round_ctrl.sv
// Sequencing controller for one SHA-256 compression datapath.
module sha256_round_ctrl
  import sha256_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = SHA256_ROUNDS,
  parameter int unsigned CTR_W      = CTR_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             blk_valid,
  input  logic             blk_first,
  input  logic             blk_last,
  input  logic             abort,
  output logic             blk_ready,
  output logic             w_init,
  output logic             w_next,
  output logic             digest_init,
  output logic             state_init,
  output logic             state_update,
  output logic             digest_update,
  output logic [CTR_W-1:0] round_ctr,
  output logic             busy,
  output logic             block_done,
  output logic             digest_valid
);

  state_t r_state;
  state_t w_state_nxt;
  logic   r_first;
  logic   r_last;
  logic   r_w_init;
  logic   r_state_init;
  logic   r_state_update;
  logic   r_digest_update;
  logic   r_busy;
  logic   r_block_done;
  logic   r_digest_valid;
  logic   w_accept;
  logic   w_ctr_clr;
  logic   w_ctr_en;
  logic   w_tc;

  assign blk_ready = (r_state == ST_IDLE) && !reset;
  assign w_accept  = blk_valid && blk_ready && !abort;

  // Round counter runs only in ROUNDS; SETUP, abort and terminal count clear it.
  assign w_ctr_en  = (r_state == ST_ROUNDS);
  assign w_ctr_clr = abort || (r_state == ST_SETUP) || ((r_state == ST_ROUNDS) && w_tc);

  sha256_round_ctr #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .CTR_W      (CTR_W)
  ) u_ctr (
    .i_clk (clk),
    .i_rst (reset),
    .i_clr (w_ctr_clr),
    .i_en  (w_ctr_en),
    .o_cnt (round_ctr),
    .o_tc  (w_tc)
  );

  // Next-state selection; abort returns to IDLE from any state.
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_accept) w_state_nxt = ST_LOAD;
        ST_LOAD:   w_state_nxt = ST_SETUP;
        ST_SETUP:  w_state_nxt = ST_ROUNDS;
        ST_ROUNDS: if (w_tc) w_state_nxt = ST_FINAL;
        ST_FINAL:  w_state_nxt = ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register plus strobes registered from the next state, so each
  // strobe is high exactly while the FSM sits in its state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_first         <= 1'b0;
      r_last          <= 1'b0;
      r_w_init        <= 1'b0;
      r_state_init    <= 1'b0;
      r_state_update  <= 1'b0;
      r_digest_update <= 1'b0;
      r_busy          <= 1'b0;
      r_block_done    <= 1'b0;
      r_digest_valid  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_first <= blk_first;
        r_last  <= blk_last;
      end
      r_w_init        <= (w_state_nxt == ST_LOAD);
      r_state_init    <= (w_state_nxt == ST_SETUP);
      r_state_update  <= (w_state_nxt == ST_ROUNDS);
      r_digest_update <= (w_state_nxt == ST_FINAL);
      r_busy          <= (w_state_nxt != ST_IDLE);
      r_block_done    <= (r_state == ST_FINAL) && !abort && !r_last;
      r_digest_valid  <= (r_state == ST_FINAL) && !abort && r_last;
    end
  end

  assign w_init        = r_w_init;
  assign digest_init   = r_w_init && r_first;
  assign state_init    = r_state_init;
  assign state_update  = r_state_update;
  assign w_next        = r_state_update;
  assign digest_update = r_digest_update;
  assign busy          = r_busy;
  assign block_done    = r_block_done;
  assign digest_valid  = r_digest_valid;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Scoreboard bench for sha256_round_ctrl: full-length and 16-round builds
// driven by the same stimulus, checked every cycle against a job-offset model.
module tb_sha256_round_ctrl;

  logic clk;
  logic reset;
  logic blk_valid;
  logic blk_first;
  logic blk_last;
  logic abort;

  logic       rdy64, wi64, wn64, di64, si64, su64, du64, bz64, bd64, dv64;
  logic [5:0] rc64;
  logic       rdy16, wi16, wn16, di16, si16, su16, du16, bz16, bd16, dv16;
  logic [3:0] rc16;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          cyc;
    logic [15:0] e64;
    logic [15:0] e16;
  } exp_t;

  exp_t sb[$];

  sha256_round_ctrl #(.NUM_ROUNDS(64), .CTR_W(6)) u_dut64 (
    .clk(clk), .reset(reset), .blk_valid(blk_valid), .blk_first(blk_first),
    .blk_last(blk_last), .abort(abort), .blk_ready(rdy64), .w_init(wi64),
    .w_next(wn64), .digest_init(di64), .state_init(si64), .state_update(su64),
    .digest_update(du64), .round_ctr(rc64), .busy(bz64), .block_done(bd64),
    .digest_valid(dv64)
  );

  sha256_round_ctrl #(.NUM_ROUNDS(16), .CTR_W(4)) u_dut16 (
    .clk(clk), .reset(reset), .blk_valid(blk_valid), .blk_first(blk_first),
    .blk_last(blk_last), .abort(abort), .blk_ready(rdy16), .w_init(wi16),
    .w_next(wn16), .digest_init(di16), .state_init(si16), .state_update(su16),
    .digest_update(du16), .round_ctr(rc16), .busy(bz16), .block_done(bd16),
    .digest_valid(dv16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs from the cycle offset since accept (0 = idle,
  // 1 = load, 2 = setup, 3..n+2 = rounds, n+3 = final) and the pending
  // completion kind (0 none, 1 block_done, 2 digest_valid).
  function automatic logic [15:0] expv(int p, int u, bit f, int n, bit r);
    logic       rd, wi, wn, di, si, su, du, bz, bd, dv;
    logic [5:0] rc;
    rd = (p == 0) && !r;
    wi = (p == 1);
    di = wi && f;
    si = (p == 2);
    su = (p >= 3) && (p <= n + 2);
    wn = su;
    du = (p == n + 3);
    bz = (p != 0);
    bd = (u == 1);
    dv = (u == 2);
    rc = su ? 6'(p - 3) : 6'd0;
    return {rd, wi, wn, di, si, su, du, bz, bd, dv, rc};
  endfunction

  // Monitor: pops one expectation per cycle and compares both builds.
  initial begin
    exp_t        e;
    logic [15:0] a64, a16;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        a64 = {rdy64, wi64, wn64, di64, si64, su64, du64, bz64, bd64, dv64, rc64};
        a16 = {rdy16, wi16, wn16, di16, si16, su16, du16, bz16, bd16, dv16, 2'b00, rc16};
        n_cmp++;
        if (a64 !== e.e64) begin
          n_bad++;
          $display("FAIL dut64 cycle %0d got %h exp %h", e.cyc, a64, e.e64);
        end
        n_cmp++;
        if (a16 !== e.e16) begin
          n_bad++;
          $display("FAIL dut16 cycle %0d got %h exp %h", e.cyc, a16, e.e16);
        end
      end
    end
  end

  // Stimulus and reference model.
  initial begin
    int   ph[2];
    int   pu[2];
    bit   mf[2];
    bit   ml[2];
    int   nr[2];
    bit   pv, pf, pl, pa, pr;
    bit   v, f, l, a, r;
    int   rst_left;
    exp_t e;

    nr[0] = 64;
    nr[1] = 16;
    for (int d = 0; d < 2; d++) begin
      ph[d] = 0; pu[d] = 0; mf[d] = 0; ml[d] = 0;
    end
    rst_left = 0;
    reset = 1'b1; blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0; abort = 1'b0;
    pv = 0; pf = 0; pl = 0; pa = 0; pr = 1;

    for (int k = 0; k < 2500; k++) begin
      @(posedge clk);
      #1;
      // Advance model across the edge just taken, using inputs held over it.
      for (int d = 0; d < 2; d++) begin
        if (pr || pa) begin
          ph[d] = 0; pu[d] = 0;
        end else if (ph[d] == 0) begin
          pu[d] = 0;
          if (pv) begin
            ph[d] = 1; mf[d] = pf; ml[d] = pl;
          end
        end else if (ph[d] == nr[d] + 3) begin
          ph[d] = 0;
          pu[d] = ml[d] ? 2 : 1;
        end else begin
          ph[d] = ph[d] + 1;
          pu[d] = 0;
        end
      end

      v = 0; f = 0; l = 0; a = 0; r = 0;
      if (k < 3) r = 1;
      else if (k == 3) begin v = 1; f = 1; l = 1; end
      else if (k >= 80 && k < 148) begin v = 1; f = 1; l = 0; end
      else if (k >= 148 && k < 216) begin v = 1; f = 0; l = 1; end
      else if (k >= 240 && k < 260) begin v = 1; f = 1'($urandom % 2); l = 1'($urandom % 2); end
      else if (k == 320) begin v = 1; f = 1; l = 1; end
      else if (k == 350) a = 1;
      else if (k == 360) begin v = 1; f = 1; l = 0; end
      else if (k == 440) begin v = 1; a = 1; end
      else if (k == 450) begin v = 1; f = 1; l = 1; end
      else if (k == 490 || k == 491) r = 1;
      else if (k >= 500) begin
        v = ($urandom % 3) == 0;
        f = 1'($urandom % 2);
        l = 1'($urandom % 2);
        a = ($urandom % 50) == 0;
        if (rst_left == 0 && ($urandom % 300) == 0) rst_left = 1 + int'($urandom % 2);
        if (rst_left > 0) begin
          r = 1;
          rst_left--;
        end
      end

      reset = r; blk_valid = v; blk_first = f; blk_last = l; abort = a;
      if (r) begin
        for (int d = 0; d < 2; d++) begin
          ph[d] = 0; pu[d] = 0;
        end
      end

      e.cyc = k;
      e.e64 = expv(ph[0], pu[0], mf[0], nr[0], r);
      e.e16 = expv(ph[1], pu[1], mf[1], nr[1], r);
      sb.push_back(e);
      pv = v; pf = f; pl = l; pa = a; pr = r;
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sha256_round_ctrl.md
Name: sha256_round_ctrl

Overview:
- Sequencing controller for one SHA-256 compression datapath: the message-schedule memory, the working registers a..h, and the H0..H7 digest registers.
- Accepts 512-bit block jobs over a valid/ready handshake, then drives the schedule init/next strobes and the working-state load/update strobes.
- Supplies the round index for K-constant lookup and signals block and message completion.
- One instance sits beside each hashing core of the multi-core array.

Parameters:
- NUM_ROUNDS, 64, compression rounds per block; legal range 16..64, reduced values for bench only.
- CTR_W, 6, width of round_ctr; must satisfy 2**CTR_W >= NUM_ROUNDS.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- blk_valid  in  1  requester presents a block; the block data goes straight to the schedule memory.
- blk_first  in  1  block is the first of a message (digest loads IV); sampled only at accept.
- blk_last  in  1  block is the last of a message; sampled only at accept.
- abort  in  1  synchronous cancel of the current job.
- blk_ready  out  1  controller can accept a block.
- w_init  out  1  load schedule memory from block; resets schedule counter.
- w_next  out  1  advance schedule memory one round.
- digest_init  out  1  load H0..H7 with the SHA-256 IV.
- state_init  out  1  load a..h from H0..H7.
- state_update  out  1  execute one compression round.
- digest_update  out  1  H(i) <= H(i) + a..h.
- round_ctr  out  CTR_W  current round index, K address.
- busy  out  1  job in progress.
- block_done  out  1  one-cycle pulse: non-last block finished.
- digest_valid  out  1  one-cycle pulse: last block finished, digest stable.

Behaviour:
- Reset (async, active-high): state IDLE, round_ctr=0, first_reg=0, last_reg=0, all strobes 0, block_done=0, digest_valid=0, busy=0. blk_ready is 0 while reset is high.
- blk_ready = (state==IDLE) && !reset, combinational. Accept = blk_valid && blk_ready && !abort. On accept, blk_first and blk_last are registered into first_reg and last_reg.
- FSM states: IDLE, LOAD, SETUP, ROUNDS, FINAL.
- IDLE: on accept go to LOAD; otherwise stay.
- LOAD (1 cycle): w_init=1; digest_init=first_reg. Go to SETUP.
- SETUP (1 cycle): state_init=1; round_ctr cleared to 0. Go to ROUNDS.
- ROUNDS (NUM_ROUNDS cycles): state_update=1 and w_next=1 every cycle; round_ctr increments from 0 to NUM_ROUNDS-1. When round_ctr==NUM_ROUNDS-1, go to FINAL and clear round_ctr to 0. round_ctr never wraps past NUM_ROUNDS-1.
- FINAL (1 cycle): digest_update=1. Go to IDLE. The completion pulse is registered, so it is high in the first IDLE cycle: digest_valid=last_reg, block_done=!last_reg.
- Strobes are Moore outputs decoded from the state. At most one of w_init, state_init, state_update, digest_update is high in any cycle, except that w_next is always paired with state_update.
- busy=1 in every state other than IDLE.
- Timing: with accept at cycle 0, LOAD is cycle 1, SETUP cycle 2, ROUNDS cycles 3..NUM_ROUNDS+2, FINAL cycle NUM_ROUNDS+3. The completion pulse and blk_ready=1 occur at cycle NUM_ROUNDS+4 (68 for the default). A back-to-back accept is possible in that same cycle.
- abort: in any state, the next state is IDLE, round_ctr=0, and no completion pulse is produced. Strobes drop in the next cycle. Abort in FINAL suppresses the pulse, but the digest_update already issued stands.
- abort together with blk_valid in IDLE: abort wins, no accept.
- blk_valid while busy is ignored; blk_first and blk_last are ignored outside accept.
- blk_first=1 with blk_last=1 is a single-block message, legal.
- A non-first block after a completed message is not checked; the requester is responsible.
- Reset asserted mid-ROUNDS: immediate return to the reset values; no pulse after release.

Decomposition:
- Package sha256_ctrl_pkg: FSM state encoding (3-bit, IDLE=0), SHA256_ROUNDS=64, SHA256_SCHED_WORDS=16, CTR_W default.
- One sub-module, sha256_round_ctr: clearable, enabled up-counter with a terminal-count flag at NUM_ROUNDS-1. The FSM and output decode stay in the top module.

Test Plan:
- Single-block message: accept with first=1, last=1 at cycle 0 -> w_init and digest_init at cycle 1; state_init at cycle 2; state_update and w_next at cycles 3..66 with round_ctr 0..63; digest_update at cycle 67; digest_valid=1 and blk_ready=1 at cycle 68; block_done stays 0.
- Two-block message, back-to-back: block A (first=1, last=0), then block B (first=0, last=1) accepted at cycle 68 -> block_done pulse at 68; for B, digest_init=0 at LOAD; digest_valid at 136.
- Abort at cycle 30 (round_ctr=27) -> cycle 31: IDLE, all strobes 0, round_ctr=0; no pulse ever; next accept runs the full 68-cycle sequence.
- Async reset pulse at cycle 40 (mid-ROUNDS, not aligned to a clock edge) -> outputs at reset values immediately; blk_ready=0 while reset is high, 1 on the first clock after release.
- abort and blk_valid both high in IDLE -> no accept, busy stays 0. blk_valid held high for the whole job -> exactly one accept per 68 cycles.
- NUM_ROUNDS=16 build: accept at cycle 0 -> round_ctr 0..15 over cycles 3..18, digest_update at 19, completion pulse at 20.
